// File: rtl/decode_hazard_ctrl.sv
`default_nettype none
// =============================================================================
// decode_hazard_ctrl : decode-stage scoreboard with RAW/overflow stall and
//                      post-branch decode flush sequencing.  Rev 1.0
// =============================================================================
module decode_hazard_ctrl #(
  parameter int          NUM_REGS  = 16,
  parameter int          CNT_W     = 2,
  parameter logic [15:0] WR_MASK   = 16'h00FF,
  parameter logic [15:0] SRC2_MASK = 16'h00FF,
  parameter bit          WB_BYPASS = 1'b1,
  parameter int          FLUSH_CYC = 1,
  parameter int          STALL_MAX = 64,
  localparam int         AW        = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_valid,
  input  logic [3:0]          opcodeDP,
  input  logic [AW-1:0]       srcAdd1,
  input  logic [AW-1:0]       srcAdd2,
  input  logic [AW-1:0]       destaddD,
  input  logic                InstBranch,
  input  logic                write_en,
  input  logic [AW-1:0]       destAddW,
  output logic                issue,
  output logic                stallD,
  output logic                flushD,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [1:0]          state,
  output logic [15:0]         stall_count,
  output logic                sb_err,
  output logic                deadlock_err
);

  localparam int             RW        = $clog2(STALL_MAX + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic [1:0]       flush_cnt_q, flush_cnt_d;
  logic             flushD_q, flushD_d;
  logic [15:0]      stall_count_q, stall_count_d;
  logic [RW-1:0]    run_q, run_d;
  logic             sb_err_q, sb_err_d;
  logic             deadlock_q, deadlock_d;

  logic [CNT_W-1:0] cnt1, cnt2, cntd;
  logic             byp1, byp2, hz1, hz2, ovf, hazard, not_flush;

  // A source whose last outstanding write is landing right now is not a hazard.
  always_comb begin
    cnt1      = cnt_q[srcAdd1];
    cnt2      = cnt_q[srcAdd2];
    cntd      = cnt_q[destaddD];
    byp1      = WB_BYPASS && write_en && (destAddW == srcAdd1) && (cnt1 == C_CNT_ONE);
    byp2      = WB_BYPASS && write_en && (destAddW == srcAdd2) && (cnt2 == C_CNT_ONE);
    hz1       = (cnt1 != '0) && !byp1;
    hz2       = SRC2_MASK[opcodeDP] && (cnt2 != '0) && !byp2;
    ovf       = WR_MASK[opcodeDP] && (cntd == C_CNT_MAX);
    hazard    = inst_valid && (hz1 || hz2 || ovf);
    not_flush = (state_q != ST_FLUSH);
    stallD    = reset && hazard && not_flush;
    issue     = reset && inst_valid && !hazard && not_flush;
  end

  always_comb begin
    logic inc, dec;
    sb_err_d = sb_err_q;
    busy_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc      = issue && WR_MASK[opcodeDP] && (destaddD == AW'(r));
      dec      = write_en && (destAddW == AW'(r));
      cnt_d[r] = cnt_q[r];
      if (dec && (cnt_q[r] == '0))
        sb_err_d = 1'b1;
      if (inc && !dec)
        cnt_d[r] = cnt_q[r] + C_CNT_ONE;
      else if (dec && !inc && (cnt_q[r] != '0))
        cnt_d[r] = cnt_q[r] - C_CNT_ONE;
      busy_vec[r] = (cnt_q[r] != '0);
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (issue && InstBranch) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = 2'(FLUSH_CYC);
        end else if (stallD) begin
          state_d = ST_STALL;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        flush_cnt_d = flush_cnt_q - 2'd1;
        if (flush_cnt_q == 2'd1)
          state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    flushD_d      = (state_d == ST_FLUSH);
    stall_count_d = (stallD && (stall_count_q != 16'hFFFF)) ? stall_count_q + 16'd1 : stall_count_q;
    run_d         = !stallD ? '0 : ((run_q == RW'(STALL_MAX)) ? run_q : run_q + RW'(1));
    deadlock_d    = deadlock_q || (run_d == RW'(STALL_MAX));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      flush_cnt_q   <= '0;
      flushD_q      <= 1'b0;
      stall_count_q <= '0;
      run_q         <= '0;
      sb_err_q      <= 1'b0;
      deadlock_q    <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      flushD_q      <= flushD_d;
      stall_count_q <= stall_count_d;
      run_q         <= run_d;
      sb_err_q      <= sb_err_d;
      deadlock_q    <= deadlock_d;
      for (int r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= cnt_d[r];
    end
  end

  assign flushD       = flushD_q;
  assign state        = state_q;
  assign stall_count  = stall_count_q;
  assign sb_err       = sb_err_q;
  assign deadlock_err = deadlock_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_hazard_ctrl.sv
`default_nettype none
// Bench for decode_hazard_ctrl: directed scenarios then random traffic,
// compared each cycle against a behavioural scoreboard model.
module tb_decode_hazard_ctrl;

  localparam logic [15:0] WRM   = 16'h00FF;
  localparam logic [15:0] S2M   = 16'h00FF;
  localparam int          FLUSH = 1;
  localparam int          SMAX  = 64;

  logic        clk = 1'b0;
  logic        reset, inst_valid, InstBranch, write_en;
  logic [3:0]  opcodeDP, srcAdd1, srcAdd2, destaddD, destAddW;
  logic        issue, stallD, flushD, sb_err, deadlock_err;
  logic [15:0] busy_vec, stall_count;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  int m_cnt [16];
  int m_state, m_fl, m_sc, m_run;
  bit m_sb, m_dl, e_issue, e_stall;

  decode_hazard_ctrl #(
    .NUM_REGS(16), .CNT_W(2), .WR_MASK(WRM), .SRC2_MASK(S2M),
    .WB_BYPASS(1'b1), .FLUSH_CYC(FLUSH), .STALL_MAX(SMAX)
  ) dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .opcodeDP(opcodeDP),
    .srcAdd1(srcAdd1), .srcAdd2(srcAdd2), .destaddD(destaddD),
    .InstBranch(InstBranch), .write_en(write_en), .destAddW(destAddW),
    .issue(issue), .stallD(stallD), .flushD(flushD), .busy_vec(busy_vec),
    .state(state), .stall_count(stall_count), .sb_err(sb_err),
    .deadlock_err(deadlock_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input int op, input int s1, input int s2,
                       input int d, input bit br, input bit we, input int wa);
    inst_valid = v;   opcodeDP = 4'(op); srcAdd1 = 4'(s1); srcAdd2 = 4'(s2);
    destaddD   = 4'(d); InstBranch = br; write_en = we;    destAddW = 4'(wa);
  endtask

  function automatic bit blocked(input logic [3:0] s);
    return (m_cnt[s] != 0) && !(write_en && destAddW == s && m_cnt[s] == 1);
  endfunction

  function automatic logic [15:0] m_busy();
    logic [15:0] b = '0;
    for (int r = 0; r < 16; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  task automatic check_regs();
    chk("busy_vec", busy_vec, m_busy());
    chk("state", state, m_state);
    chk("flushD", flushD, m_state == 2);
    chk("stall_count", stall_count, m_sc);
    chk("sb_err", sb_err, m_sb);
    chk("deadlock_err", deadlock_err, m_dl);
  endtask

  // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
  task automatic cycle();
    bit wr, haz, inc, dec;
    wr  = WRM[opcodeDP];
    haz = inst_valid && (blocked(srcAdd1) || (S2M[opcodeDP] && blocked(srcAdd2)) ||
                         (wr && m_cnt[destaddD] == 3));
    e_stall = (m_state != 2) && haz;
    e_issue = (m_state != 2) && inst_valid && !haz;
    #2;
    chk("issue", issue, e_issue);
    chk("stallD", stallD, e_stall);
    @(posedge clk);
    for (int r = 0; r < 16; r++) begin
      inc = e_issue && wr && destaddD == 4'(r);
      dec = write_en && destAddW == 4'(r);
      if (dec && m_cnt[r] == 0) m_sb = 1'b1;
      if (inc && !dec) m_cnt[r]++;
      else if (dec && !inc && m_cnt[r] > 0) m_cnt[r]--;
    end
    if (m_state == 2) begin
      m_fl--;
      if (m_fl == 0) m_state = 0;
    end else if (e_issue && InstBranch) begin
      m_state = 2; m_fl = FLUSH;
    end else m_state = e_stall ? 1 : 0;
    if (e_stall) begin
      if (m_sc < 65535) m_sc++;
      m_run++;
      if (m_run >= SMAX) m_dl = 1'b1;
    end else m_run = 0;
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    for (int r = 0; r < 16; r++) m_cnt[r] = 0;
    m_state = 0; m_fl = 0; m_sc = 0; m_run = 0; m_sb = 0; m_dl = 0;
    chk("rst_issue", issue, 0);
    chk("rst_stallD", stallD, 0);
    check_regs();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // Independent writes to r1 and r2
    drive(1, 0, 0, 0, 1, 0, 0, 0); cycle();
    drive(1, 1, 0, 0, 2, 0, 0, 0); cycle();
    chk("t1_busy", busy_vec, 16'h0006);

    // RAW on r3 resolved by a writeback three cycles later
    do_reset();
    drive(1, 0, 0, 0, 3, 0, 0, 0); cycle();
    drive(1, 1, 3, 0, 4, 0, 0, 0);
    repeat (3) cycle();
    drive(1, 1, 3, 0, 4, 0, 1, 3); cycle();
    chk("t2_issue_on_wb", e_issue, 1);
    chk("t2_stall_count", stall_count, 16'd3);

    // Counter overflow on r5
    do_reset();
    drive(1, 2, 0, 0, 5, 0, 0, 0);
    repeat (3) cycle();
    cycle();
    chk("t3_ovf_stall", stallD, 1);

    // Branch flush with inst_valid ignored and busy_vec held
    do_reset();
    drive(1, 0, 0, 0, 4, 0, 0, 0); cycle();
    drive(1, 9, 0, 0, 6, 1, 0, 0); cycle();
    chk("t4_flush", flushD, 1);
    drive(1, 0, 0, 0, 5, 0, 0, 0);
    repeat (FLUSH) cycle();
    cycle();
    chk("t4_busy", busy_vec, 16'h0030);

    // Coincident issue/writeback on r7, then a stray writeback to r9
    do_reset();
    drive(1, 0, 0, 0, 7, 0, 0, 0); cycle();
    drive(1, 0, 0, 0, 7, 0, 1, 7); cycle();
    chk("t5_busy_r7", busy_vec[7], 1);
    drive(0, 0, 0, 0, 0, 0, 1, 9); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0); cycle();
    chk("t5_sb_err", sb_err, 1);

    // Deadlock detection, then reset pulled mid-stall
    do_reset();
    drive(1, 0, 0, 0, 2, 0, 0, 0); cycle();
    drive(1, 3, 2, 0, 8, 0, 0, 0);
    repeat (SMAX - 1) cycle();
    chk("t6_no_deadlock_yet", deadlock_err, 0);
    cycle();
    chk("t6_deadlock", deadlock_err, 1);
    do_reset();

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      int w;
      bit v, br, we;
      if (i % 200 == 199) do_reset();
      v  = ($urandom_range(0, 9) < 7);
      br = ($urandom_range(0, 7) == 0);
      w  = $urandom_range(0, 5);
      we = (m_cnt[w] != 0) && ($urandom_range(0, 9) < 5);
      drive(v, br ? $urandom_range(8, 15) : $urandom_range(0, 15),
            $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
            br, we, w);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
